// File: rtl/v_pkg.sv
// Shared types for the list query pipeline and its response buffer.
package v_pkg;

   localparam int unsigned KEY_W      = 8;
   localparam int unsigned VOLUME_W   = 8;
   localparam int unsigned LISTSIZE_W = 4;

   typedef logic [KEY_W-1:0]      key_t;
   typedef logic [VOLUME_W-1:0]   volume_t;
   typedef logic [LISTSIZE_W-1:0] listsize_t;

   // One buffered query result.
   typedef struct packed {
      key_t      key;
      volume_t   size;
      listsize_t listsize;
      logic      error;
   } rsp_t;

endpackage

// File: rtl/v_pipe_query_rsp_if.sv
// Query result input and host response handshake.
interface v_pipe_query_rsp_if;

   logic               i_lut_vld_r;
   v_pkg::key_t        i_lut_key;
   v_pkg::volume_t     i_lut_size;
   logic               i_lut_error;
   v_pkg::listsize_t   i_lut_listsize;

   logic               o_rsp_vld;
   v_pkg::key_t        o_rsp_key;
   v_pkg::volume_t     o_rsp_size;
   logic               o_rsp_error;
   v_pkg::listsize_t   o_rsp_listsize;
   logic               i_rsp_accept;

   // Producer of query results and consumer of responses.
   modport master (
      output i_lut_vld_r, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
      output i_rsp_accept,
      input  o_rsp_vld, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize
   );

   // The response buffer.
   modport slave (
      input  i_lut_vld_r, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
      input  i_rsp_accept,
      output o_rsp_vld, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize
   );

endinterface

// File: rtl/v_pipe_query_rsp.sv
// Response FIFO behind the non-stallable query pipeline; overflow is dropped and counted.
module v_pipe_query_rsp #(
   parameter  int unsigned DEPTH      = 4,
   parameter  int unsigned DROP_CNT_W = 8,
   localparam int unsigned PTR_W      = $clog2(DEPTH),
   localparam int unsigned LVL_W      = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   v_pipe_query_rsp_if.slave     bus,
   output logic [LVL_W-1:0]      o_level,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DROP_CNT_W-1:0] o_drop_cnt,
   output logic                  o_drop_sticky,
   input  logic                  i_drop_clr
);

   v_pkg::rsp_t mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic                  pop_c;
   logic                  push_c;
   logic                  drop_c;
   v_pkg::rsp_t           wr_entry_c;
   v_pkg::rsp_t           head_c;
   logic [LVL_W-1:0]      level_nxt_c;
   logic [DROP_CNT_W-1:0] drop_cnt_nxt_c;
   logic                  drop_sticky_nxt_c;

   // Handshake decode, error masking and next occupancy / drop state.
   always_comb begin
      pop_c             = 1'b0;
      push_c            = 1'b0;
      drop_c            = 1'b0;
      wr_entry_c        = '0;
      level_nxt_c       = o_level;
      drop_cnt_nxt_c    = o_drop_cnt;
      drop_sticky_nxt_c = o_drop_sticky;

      pop_c  = ~o_empty & bus.i_rsp_accept;
      push_c = bus.i_lut_vld_r & (~o_full | pop_c);
      drop_c = bus.i_lut_vld_r & o_full & ~pop_c;

      if (bus.i_lut_error) begin
         wr_entry_c.error = 1'b1;
      end else begin
         wr_entry_c.key      = bus.i_lut_key;
         wr_entry_c.size     = bus.i_lut_size;
         wr_entry_c.listsize = bus.i_lut_listsize;
         wr_entry_c.error    = 1'b0;
      end

      if (push_c && !pop_c) begin
         level_nxt_c = o_level + LVL_W'(1);
      end else if (pop_c && !push_c) begin
         level_nxt_c = o_level - LVL_W'(1);
      end

      // A drop in the same cycle as a clear still leaves a record of itself.
      if (drop_c) begin
         drop_sticky_nxt_c = 1'b1;
         if (i_drop_clr) begin
            drop_cnt_nxt_c = DROP_CNT_W'(1);
         end else if (o_drop_cnt != '1) begin
            drop_cnt_nxt_c = o_drop_cnt + DROP_CNT_W'(1);
         end
      end else if (i_drop_clr) begin
         drop_cnt_nxt_c    = '0;
         drop_sticky_nxt_c = 1'b0;
      end
   end

   // Pointers, occupancy flags and drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         o_level       <= '0;
         o_full        <= 1'b0;
         o_empty       <= 1'b1;
         o_drop_cnt    <= '0;
         o_drop_sticky <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         o_level       <= level_nxt_c;
         o_full        <= (level_nxt_c == LVL_W'(DEPTH));
         o_empty       <= (level_nxt_c == '0);
         o_drop_cnt    <= drop_cnt_nxt_c;
         o_drop_sticky <= drop_sticky_nxt_c;
      end
   end

   // Entry storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push_c && !rst) mem[wr_ptr] <= wr_entry_c;
   end

   // Head presentation, zeroed when nothing is buffered.
   assign head_c             = o_empty ? '0 : mem[rd_ptr];
   assign bus.o_rsp_vld      = ~o_empty;
   assign bus.o_rsp_key      = head_c.key;
   assign bus.o_rsp_size     = head_c.size;
   assign bus.o_rsp_listsize = head_c.listsize;
   assign bus.o_rsp_error    = head_c.error;

`ifndef SYNTHESIS
   // Occupancy bounds and head stability under backpressure.
   a_level_max : assert property (@(posedge clk) o_level <= LVL_W'(DEPTH));
   a_full_empty : assert property (@(posedge clk) !(o_full && o_empty));
   a_head_stable : assert property (@(posedge clk) disable iff (rst)
      (bus.o_rsp_vld && !bus.i_rsp_accept) |=> $stable(head_c));
`endif

endmodule

// File: tb/tb_v_pipe_query_rsp.sv
// Directed bench for the query response buffer (DEPTH=4, DROP_CNT_W=2).
module tb_v_pipe_query_rsp;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned DROP_CNT_W = 2;
   localparam int unsigned LVL_W      = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst;
   logic [LVL_W-1:0]      level;
   logic                  full;
   logic                  empty;
   logic [DROP_CNT_W-1:0] drop_cnt;
   logic                  drop_sticky;
   logic                  drop_clr;

   int checks = 0;
   int errors = 0;

   v_pipe_query_rsp_if bus ();

   v_pipe_query_rsp #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .o_level       (level),
      .o_full        (full),
      .o_empty       (empty),
      .o_drop_cnt    (drop_cnt),
      .o_drop_sticky (drop_sticky),
      .i_drop_clr    (drop_clr)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it differs.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] key, input logic [7:0] size,
                        input logic [3:0] ls, input logic err);
      bus.i_lut_vld_r    = 1'b1;
      bus.i_lut_key      = key;
      bus.i_lut_size     = size;
      bus.i_lut_listsize = ls;
      bus.i_lut_error    = err;
   endtask

   task automatic push(input logic [7:0] key, input logic [7:0] size,
                       input logic [3:0] ls, input logic err);
      drive(key, size, ls, err);
      step();
      bus.i_lut_vld_r = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      drop_clr           = 1'b0;
      bus.i_lut_vld_r    = 1'b0;
      bus.i_lut_key      = '0;
      bus.i_lut_size     = '0;
      bus.i_lut_listsize = '0;
      bus.i_lut_error    = 1'b0;
      bus.i_rsp_accept   = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_vld", 32'(bus.o_rsp_vld), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_sticky", 32'(drop_sticky), 32'd0);
      check("rst_key", 32'(bus.o_rsp_key), 32'd0);

      // Single result, consumer always ready
      bus.i_rsp_accept = 1'b1;
      push(8'h12, 8'h34, 4'd3, 1'b0);
      check("single_vld", 32'(bus.o_rsp_vld), 32'd1);
      check("single_key", 32'(bus.o_rsp_key), 32'h12);
      check("single_size", 32'(bus.o_rsp_size), 32'h34);
      check("single_ls", 32'(bus.o_rsp_listsize), 32'd3);
      check("single_err", 32'(bus.o_rsp_error), 32'd0);
      check("single_level", 32'(level), 32'd1);
      step();
      check("single_vld_off", 32'(bus.o_rsp_vld), 32'd0);
      check("single_level0", 32'(level), 32'd0);
      check("single_key0", 32'(bus.o_rsp_key), 32'd0);

      // Error masking
      bus.i_rsp_accept = 1'b0;
      push(8'hAB, 8'h55, 4'd7, 1'b1);
      check("err_vld", 32'(bus.o_rsp_vld), 32'd1);
      check("err_key", 32'(bus.o_rsp_key), 32'd0);
      check("err_size", 32'(bus.o_rsp_size), 32'd0);
      check("err_ls", 32'(bus.o_rsp_listsize), 32'd0);
      check("err_flag", 32'(bus.o_rsp_error), 32'd1);
      step();
      check("err_stalled_flag", 32'(bus.o_rsp_error), 32'd1);
      bus.i_rsp_accept = 1'b1;
      step();
      bus.i_rsp_accept = 1'b0;
      check("err_drained", 32'(empty), 32'd1);

      // Fill then overflow
      for (int k = 1; k <= 6; k++) push(8'(k), 8'(k + 16), 4'(k), 1'b0);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      check("ovf_sticky", 32'(drop_sticky), 32'd1);
      bus.i_rsp_accept = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("ovf_drain_key", 32'(bus.o_rsp_key), 32'(k));
         check("ovf_drain_size", 32'(bus.o_rsp_size), 32'(k + 16));
         step();
      end
      bus.i_rsp_accept = 1'b0;
      check("ovf_empty", 32'(empty), 32'd1);
      check("ovf_vld_off", 32'(bus.o_rsp_vld), 32'd0);

      // Clear with no drop
      drop_clr = 1'b1;
      step();
      drop_clr = 1'b0;
      check("clr_cnt", 32'(drop_cnt), 32'd0);
      check("clr_sticky", 32'(drop_sticky), 32'd0);

      // Full with simultaneous push and pop
      for (int k = 1; k <= 4; k++) push(8'(k), 8'h00, 4'd1, 1'b0);
      check("pp_full", 32'(full), 32'd1);
      bus.i_rsp_accept = 1'b1;
      push(8'd5, 8'h00, 4'd1, 1'b0);
      bus.i_rsp_accept = 1'b0;
      check("pp_level", 32'(level), 32'd4);
      check("pp_head", 32'(bus.o_rsp_key), 32'd2);
      check("pp_no_drop", 32'(drop_cnt), 32'd0);
      check("pp_no_sticky", 32'(drop_sticky), 32'd0);
      bus.i_rsp_accept = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         check("pp_drain_key", 32'(bus.o_rsp_key), 32'(k));
         step();
      end
      bus.i_rsp_accept = 1'b0;
      check("pp_empty", 32'(empty), 32'd1);

      // Counter saturation and clear
      for (int k = 1; k <= 4; k++) push(8'(k), 8'h00, 4'd0, 1'b0);
      for (int k = 0; k < 5; k++) push(8'hEE, 8'h00, 4'd0, 1'b0);
      check("sat_cnt", 32'(drop_cnt), 32'd3);
      check("sat_sticky", 32'(drop_sticky), 32'd1);
      check("sat_head", 32'(bus.o_rsp_key), 32'd1);
      drop_clr = 1'b1;
      step();
      check("sat_clr_cnt", 32'(drop_cnt), 32'd0);
      check("sat_clr_sticky", 32'(drop_sticky), 32'd0);
      drive(8'hEE, 8'h00, 4'd0, 1'b0);
      step();
      bus.i_lut_vld_r = 1'b0;
      drop_clr        = 1'b0;
      check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
      check("clr_drop_sticky", 32'(drop_sticky), 32'd1);

      // Reset mid-stream with three entries stalled
      bus.i_rsp_accept = 1'b1;
      step();
      bus.i_rsp_accept = 1'b0;
      check("mid_level3", 32'(level), 32'd3);
      rst              = 1'b1;
      bus.i_rsp_accept = 1'b1;
      drive(8'h77, 8'h00, 4'd0, 1'b0);
      step();
      rst              = 1'b0;
      bus.i_rsp_accept = 1'b0;
      bus.i_lut_vld_r  = 1'b0;
      check("mid_vld", 32'(bus.o_rsp_vld), 32'd0);
      check("mid_level", 32'(level), 32'd0);
      check("mid_drop_cnt", 32'(drop_cnt), 32'd0);
      check("mid_sticky", 32'(drop_sticky), 32'd0);
      push(8'h9C, 8'h21, 4'd5, 1'b0);
      check("post_vld", 32'(bus.o_rsp_vld), 32'd1);
      check("post_key", 32'(bus.o_rsp_key), 32'h9C);
      check("post_size", 32'(bus.o_rsp_size), 32'h21);
      check("post_ls", 32'(bus.o_rsp_listsize), 32'd5);
      check("post_level", 32'(level), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
